xadc_drp_sequencer: RTL and testbench
=====================================

// Module: xadc_drp_sequencer
// PURPOSE
//   Round-robin scheduler that reads XADC conversion results over the DRP port, one channel per EOC.
//   Returns each result as a one-cycle strobe with the channel index, so the strobe can drive the EN of
//   that channel's moving-average filter. Sits between the XADC primitive and the per-channel averagers.
//   Provides pending-EOC buffering, DRP timeout recovery and sticky error flags.
// PARAMETERS
//   NUM_CH     4      channels in rotation (1..16); channel i is read at DRP address BASE_ADDR+i
//   BASE_ADDR  7'h10  DRP address of channel 0 (VAUX0 status register)
//   ADC_BITS   12     result width; taken from do_data[15:16-ADC_BITS]
//   TIMEOUT    63     max cycles waited for drdy after den (1..255)
// PORTS
//   clk            in   1                 system clock
//   reset          in   1                 synchronous, active-high
//   enable         in   1                 1 = service EOC events; 0 = finish current access, then idle
//   clear_err      in   1                 one-cycle pulse; clears timeout_err and overrun_err
//   eoc            in   1                 XADC end-of-conversion pulse
//   den            out  1                 DRP enable, one-cycle pulse per access
//   dwe            out  1                 DRP write enable, tied 0 (read-only block)
//   daddr          out  7                 DRP address; valid while den=1, held until access ends
//   drdy           in   1                 DRP read-data-ready, one-cycle pulse
//   do_data        in   16                DRP read data, valid when drdy=1
//   sample_valid   out  1                 one-cycle strobe: sample_data/sample_ch valid
//   sample_data    out  ADC_BITS          captured conversion result
//   sample_ch      out  max(1,$clog2(NUM_CH))  channel index of sample_data
//   busy           out  1                 1 while in REQ or WAIT
//   timeout_err    out  1                 sticky: a DRP access timed out
//   overrun_err    out  1                 sticky: an EOC was dropped
// BEHAVIOUR
//   Reset: all outputs are 0; FSM=IDLE; ch_idx=0; pending=0; timeout counter=0. Reset overrides any access
//     in flight. den drops the cycle after reset is sampled.
//   FSM states: IDLE, REQ, WAIT.
//     IDLE -> REQ  when enable=1 and (eoc=1 or pending=1); clear pending.
//     REQ  -> WAIT after exactly 1 cycle. den=1 only in REQ; daddr=BASE_ADDR+ch_idx (7-bit add, no carry out).
//     WAIT -> IDLE on drdy=1. Capture do_data[15:16-ADC_BITS] and ch_idx. Next cycle: sample_valid=1 for
//       exactly 1 cycle. ch_idx advances.
//     WAIT -> IDLE when the counter reaches TIMEOUT with no drdy. Set timeout_err; no sample_valid;
//       ch_idx advances (skip channel).
//   Latency: eoc in IDLE -> den next cycle. drdy -> sample_valid next cycle.
//   ch_idx wraps from NUM_CH-1 to 0. With NUM_CH=1, ch_idx stays 0.
//   EOC buffering: an eoc seen in REQ/WAIT sets pending (1 deep).
//     eoc while pending=1 already -> drop the event, set overrun_err.
//     eoc in the same cycle IDLE consumes pending -> set pending again (not dropped).
//   drdy outside WAIT is ignored.
//   drdy in the same cycle the timeout expires -> counts as success; no error.
//   enable=0: no new access starts. An access in flight completes normally. pending is kept and is serviced
//     when enable returns to 1. eoc with enable=0 in IDLE is ignored.
//   clear_err has priority below a same-cycle set (set wins).
//   sample_data/sample_ch hold their last values between strobes.
// TESTING
//   1 NUM_CH=4; 8 EOCs, each drdy 3 cycles after den -> daddr 10,11,12,13,10.. and sample_ch 0,1,2,3,0..;
//     sample_valid 1 cycle after each drdy.
//   2 do_data=16'hABC0 with ADC_BITS=12 -> sample_data=12'hABC.
//   3 drdy withheld -> den + TIMEOUT cycles: timeout_err=1, no sample_valid. Next EOC reads the next channel.
//     clear_err -> timeout_err=0.
//   4 EOC during WAIT -> second access starts the cycle after return to IDLE.
//     Two EOCs during WAIT -> overrun_err=1 and only one extra access.
//   5 reset asserted in WAIT -> next cycle den=0, busy=0, all outputs 0.
//     Late drdy after reset -> no sample_valid. ch_idx=0 on the next access.
//   6 enable=0 mid-WAIT -> that sample is delivered and no further den.
//     enable=1 with pending set -> den next cycle.

Source files
------------

// File: rtl/xadc_drp_sequencer.sv
// Round-robin XADC DRP reader: on each EOC, read the next channel's result and emit it as a one-cycle strobe.
// Latency: eoc -> den 1 cycle, drdy -> sample_valid 1 cycle; one pending EOC buffered, timeouts skip the channel.
module xadc_drp_sequencer #(
    parameter int          NUM_CH    = 4,
    parameter logic [6:0]  BASE_ADDR = 7'h10,
    parameter int          ADC_BITS  = 12,
    parameter int          TIMEOUT   = 63,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear_err,
    input  logic                eoc,
    output logic                den,
    output logic                dwe,
    output logic [6:0]          daddr,
    input  logic                drdy,
    input  logic [15:0]         do_data,
    output logic                sample_valid,
    output logic [ADC_BITS-1:0] sample_data,
    output logic [CH_W-1:0]     sample_ch,
    output logic                busy,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [CH_W-1:0] ch_idx;
    logic [CH_W-1:0] ch_next;
    logic            pending;
    logic [7:0]      cnt;
    logic            start;
    logic            timeout_hit;
    logic            drop;

    assign start       = (state == S_IDLE) && enable && (eoc || pending);
    assign timeout_hit = (state == S_WAIT) && !drdy && (cnt == TO_LAST);
    // A second EOC while one is already buffered is lost.
    assign drop        = (state != S_IDLE) && eoc && pending;
    assign ch_next     = (ch_idx == LAST_CH) ? '0 : ch_idx + CH_W'(1);

    assign den  = (state == S_REQ);
    assign busy = (state != S_IDLE);
    assign dwe  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ch_idx       <= '0;
            pending      <= 1'b0;
            cnt          <= '0;
            daddr        <= '0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_REQ;
                        daddr   <= BASE_ADDR + 7'(ch_idx);
                        // Consuming the buffered EOC while a new one arrives keeps it buffered.
                        pending <= eoc && pending;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    if (drdy) begin
                        state        <= S_IDLE;
                        sample_valid <= 1'b1;
                        sample_data  <= do_data[15 -: ADC_BITS];
                        sample_ch    <= ch_idx;
                        ch_idx       <= ch_next;
                    end else if (cnt == TO_LAST) begin
                        state  <= S_IDLE;
                        ch_idx <= ch_next;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if ((state != S_IDLE) && eoc)
                pending <= 1'b1;

            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;

            if (drop)
                overrun_err <= 1'b1;
            else if (clear_err)
                overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer: expected samples queued when drdy is driven, checked on each strobe.
module tb_xadc_drp_sequencer;

    localparam int TO = 10;

    typedef struct packed {
        logic [1:0]  ch;
        logic [11:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, enable, clear_err, eoc, drdy;
    logic [15:0] do_data;
    logic        den, dwe, sample_valid, busy, timeout_err, overrun_err;
    logic [6:0]  daddr;
    logic [11:0] sample_data;
    logic [1:0]  sample_ch;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_ch  = 0;
    logic den_seen;

    xadc_drp_sequencer #(.NUM_CH(4), .BASE_ADDR(7'h10), .ADC_BITS(12), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err), .eoc(eoc),
        .den(den), .dwe(dwe), .daddr(daddr), .drdy(drdy), .do_data(do_data),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ch(sample_ch),
        .busy(busy), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and score any strobe against the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sample_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'(sample_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("sample_ch", 32'(sample_ch), 32'(e.ch));
                chk("sample_data", 32'(sample_data), 32'(e.data));
            end
        end
    endtask

    task automatic give_drdy(input logic [15:0] data);
        drdy = 1'b1;
        do_data = data;
        q.push_back('{ch: 2'(exp_ch), data: data[15:4]});
        tick();
        drdy = 1'b0;
        chk("strobe_after_drdy", 32'(sample_valid), 32'd1);
        exp_ch = (exp_ch + 1) % 4;
    endtask

    task automatic access(input logic [15:0] data, input int dly);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("den_start", 32'(den), 32'd1);
        chk("daddr", 32'(daddr), 32'(7'h10 + exp_ch));
        repeat (dly) tick();
        chk("den_one_cycle", 32'(den), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
        give_drdy(data);
    endtask

    task automatic watch_no_den(input int n);
        den_seen = 1'b0;
        repeat (n) begin
            tick();
            if (den === 1'b1) den_seen = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] pat [8];
        pat = '{16'h0010, 16'h1230, 16'hFFF0, 16'h8005, 16'h7FFF, 16'h0000, 16'h5A5A, 16'hABC0};
        reset = 1'b1; enable = 1'b1; clear_err = 1'b0; eoc = 1'b0; drdy = 1'b0; do_data = '0;
        repeat (3) tick();
        chk("rst_den", 32'(den), 32'd0);
        chk("rst_dwe", 32'(dwe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_daddr", 32'(daddr), 32'd0);
        chk("rst_errs", {30'd0, timeout_err, overrun_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Round robin over eight EOCs
        for (int i = 0; i < 8; i++) begin
            access(pat[i], 3);
            tick();
        end
        chk("data_abc", 32'(sample_data), 32'hABC);
        chk("data_hold_ch", 32'(sample_ch), 32'd3);

        // Timeout with drdy withheld
        eoc = 1'b1; tick(); eoc = 1'b0;
        chk("to_den", 32'(den), 32'd1);
        repeat (TO) tick();
        chk("to_not_yet", 32'(timeout_err), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        tick();
        chk("to_set", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        exp_ch = (exp_ch + 1) % 4;
        access(16'h1230, 3);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("to_clear", 32'(timeout_err), 32'd0);
        access(16'h5A50, TO);
        chk("to_boundary_ok", 32'(timeout_err), 32'd0);

        // One EOC during WAIT
        eoc = 1'b1; tick(); eoc = 1'b0;
        chk("p_den", 32'(den), 32'd1);
        tick();
        eoc = 1'b1; tick(); eoc = 1'b0;
        give_drdy(16'h4440);
        chk("p_idle_gap", 32'(den), 32'd0);
        tick();
        chk("p_second_den", 32'(den), 32'd1);
        chk("p_second_addr", 32'(daddr), 32'(7'h10 + exp_ch));
        repeat (3) tick();
        give_drdy(16'h5550);
        chk("p_no_overrun", 32'(overrun_err), 32'd0);

        // Two EOCs during WAIT
        eoc = 1'b1; tick(); eoc = 1'b0;
        tick();
        eoc = 1'b1; tick(); eoc = 1'b0;
        tick();
        eoc = 1'b1; tick(); eoc = 1'b0;
        chk("ov_set", 32'(overrun_err), 32'd1);
        give_drdy(16'h6660);
        tick();
        chk("ov_extra_den", 32'(den), 32'd1);
        repeat (3) tick();
        give_drdy(16'h7770);
        watch_no_den(5);
        chk("ov_only_one_extra", 32'(den_seen), 32'd0);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("ov_clear", 32'(overrun_err), 32'd0);

        // Reset in WAIT, then a stray drdy
        eoc = 1'b1; tick(); eoc = 1'b0;
        tick(); tick();
        chk("r_busy_before", 32'(busy), 32'd1);
        reset = 1'b1; tick();
        chk("r_den", 32'(den), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_outs", {daddr, sample_data, sample_ch, sample_valid}, 32'd0);
        reset = 1'b0;
        drdy = 1'b1; do_data = 16'hFFF0; tick(); drdy = 1'b0;
        tick();
        chk("r_no_late_strobe", 32'(sample_valid), 32'd0);
        exp_ch = 0;
        access(16'h0AB0, 2);

        // enable dropped mid-access; buffered EOC served on re-enable
        eoc = 1'b1; tick(); eoc = 1'b0;
        tick();
        enable = 1'b0;
        eoc = 1'b1; tick(); eoc = 1'b0;
        give_drdy(16'hC3C0);
        watch_no_den(4);
        chk("en_no_den", 32'(den_seen), 32'd0);
        enable = 1'b1; tick();
        chk("en_pending_den", 32'(den), 32'd1);
        chk("en_pending_addr", 32'(daddr), 32'(7'h10 + exp_ch));
        repeat (2) tick();
        give_drdy(16'h3C30);
        tick();
        enable = 1'b0;
        eoc = 1'b1; tick(); eoc = 1'b0;
        enable = 1'b1;
        watch_no_den(3);
        chk("en_eoc_ignored", 32'(den_seen), 32'd0);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
